// File: rtl/image_uart_sender_pkg.sv
// Shared types and defaults for the image UART sender: FSM encoding, header bytes, frame sizing.
package image_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam int unsigned FRAME_BYTES_DEF  = 921600;
    localparam logic [7:0]  SYNC0_DEF        = 8'hA5;
    localparam logic [7:0]  SYNC1_DEF        = 8'h5A;
    localparam int unsigned COUNT_W          = 20;
    localparam int unsigned FIFO_DEPTH       = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/image_uart_sender_if.sv
// Upstream byte-stream handshake between the SRAM reader and the image UART sender.
interface image_uart_sender_if;
    logic       i_send;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       o_ready;

    modport master (output i_send, output i_data, output i_data_valid, input o_ready);
    modport slave  (input i_send, input i_data, input i_data_valid, output o_ready);
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 UART serializer; o_idle also rises in the final stop-bit cycle so a new load
// continues back-to-back without an idle gap.
module uart_tx_core
    import image_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_idle
);
    localparam int unsigned      CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       IDX_STOP = 4'd9;

    logic             active_q, active_d;
    logic             tx_q, tx_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_tick;

    assign last_tick = (cnt_q == CNT_LAST);
    assign o_idle    = !active_q || ((idx_q == IDX_STOP) && last_tick);
    assign o_tx      = tx_q;

    always_comb begin
        active_d = active_q;
        tx_d     = tx_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        if (i_load && o_idle) begin
            active_d = 1'b1;
            tx_d     = 1'b0;
            shreg_d  = {1'b1, i_byte};
            idx_d    = '0;
            cnt_d    = '0;
        end else if (active_q) begin
            if (last_tick) begin
                cnt_d = '0;
                if (idx_q == IDX_STOP) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    // shreg holds {stop, data}; shifting in ones leaves the stop bit last
                    idx_d   = idx_q + 4'd1;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b1, shreg_q[8:1]};
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            shreg_q  <= '1;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            tx_q     <= tx_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/image_uart_sender.sv
// Frame sender: two sync bytes then FRAME_BYTES payload bytes over a UART line,
// fed through a 2-entry FIFO from an upstream valid/ready stream.
module image_uart_sender
    import image_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FRAME_BYTES  = FRAME_BYTES_DEF,
    parameter logic [7:0]  SYNC0        = SYNC0_DEF,
    parameter logic [7:0]  SYNC1        = SYNC1_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    image_uart_sender_if.slave  up,
    output logic                o_uart_tx,
    output logic                o_busy,
    output logic                o_done,
    output logic [COUNT_W-1:0]  o_byte_count,
    output logic                o_overflow
);
    localparam logic [COUNT_W-1:0] FRAME_MAX = COUNT_W'(FRAME_BYTES);

    state_e             state_q, state_d;
    logic               send_prev_q, send_prev_d;
    logic               hdr_sel_q, hdr_sel_d;
    logic [7:0]         fifo_q [FIFO_DEPTH];
    logic [7:0]         fifo_d [FIFO_DEPTH];
    logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [COUNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic               overflow_q, overflow_d;

    logic       tx_idle, tx_load, pop;
    logic [7:0] tx_byte;
    logic       start, abort, ready, push, fifo_empty, fifo_full;

    assign fifo_empty   = (fifo_cnt_q == 2'd0);
    assign fifo_full    = (fifo_cnt_q == 2'd2);
    assign start        = (state_q == ST_IDLE) && up.i_send && !send_prev_q;
    assign abort        = (state_q == ST_STREAM) && !up.i_send;
    assign ready        = (state_q == ST_STREAM) && !fifo_full && (byte_cnt_q < FRAME_MAX);
    assign push         = up.i_data_valid && ready;
    assign up.o_ready   = ready;
    assign o_byte_count = byte_cnt_q;
    assign o_overflow   = overflow_q;

    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (tx_load),
        .i_byte (tx_byte),
        .o_tx   (o_uart_tx),
        .o_idle (tx_idle)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_HEADER;
            ST_HEADER: if (tx_idle && hdr_sel_q) state_d = ST_STREAM;
            ST_STREAM: if (abort || (byte_cnt_q == FRAME_MAX)) state_d = ST_DRAIN;
            ST_DRAIN:  if (fifo_empty && tx_idle) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_load = 1'b0;
        tx_byte = fifo_q[rd_ptr_q];
        pop     = 1'b0;
        o_busy  = (state_q != ST_IDLE);
        o_done  = (state_q == ST_DONE);
        case (state_q)
            ST_HEADER: begin
                if (tx_idle) begin
                    tx_load = 1'b1;
                    tx_byte = hdr_sel_q ? SYNC1 : SYNC0;
                end
            end
            ST_STREAM: begin
                if (!abort && tx_idle && !fifo_empty) begin
                    tx_load = 1'b1;
                    pop     = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (tx_idle && !fifo_empty) begin
                    tx_load = 1'b1;
                    pop     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        send_prev_d = up.i_send;
        hdr_sel_d   = hdr_sel_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        overflow_d  = overflow_q;

        if (start) hdr_sel_d = 1'b0;
        else if ((state_q == ST_HEADER) && tx_idle) hdr_sel_d = 1'b1;

        // An abort discards queued bytes, including one accepted in the abort cycle
        if (abort) begin
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = up.i_data;
                wr_ptr_d         = !wr_ptr_q;
            end
            if (pop) rd_ptr_d = !rd_ptr_q;
            fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
        end

        if (start) byte_cnt_d = '0;
        else if (push && (byte_cnt_q < FRAME_MAX)) byte_cnt_d = byte_cnt_q + COUNT_W'(1);

        if (start) overflow_d = 1'b0;
        else if ((state_q == ST_STREAM) && up.i_data_valid && !ready) overflow_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // Treat i_send as already high so a level held through reset is not an edge
            send_prev_q <= 1'b1;
            hdr_sel_q   <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            send_prev_q <= send_prev_d;
            hdr_sel_q   <= hdr_sel_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_image_uart_sender.sv
// Directed bench for image_uart_sender with a UART line decoder and a byte feeder.
module tb_image_uart_sender;
    localparam int unsigned CPB      = 4;
    localparam int unsigned FB       = 4;
    localparam int unsigned CHAR_CYC = 10 * CPB;
    localparam logic [7:0]  HDR0     = 8'hA5;
    localparam logic [7:0]  HDR1     = 8'h5A;

    typedef struct {
        logic [7:0]  pay [4];
        int unsigned exp_count;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [3];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx, busy, done, ovf;
    logic [19:0] bcnt;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    image_uart_sender_if up_if ();

    image_uart_sender #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .up           (up_if),
        .o_uart_tx    (tx),
        .o_busy       (busy),
        .o_done       (done),
        .o_byte_count (bcnt),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line decoder: samples mid-bit, records each character and its start cycle
    logic [7:0]  rx_q [$];
    int unsigned rx_start [$];
    logic        rx_busy = 1'b0;
    logic [7:0]  rx_sh = 8'h00;
    int unsigned rx_t0 = 0, rx_off = 0, rx_nstart = 0, stop_err = 0;
    int unsigned done_total = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_t0   = cyc;
                rx_nstart++;
            end
        end else begin
            rx_off = cyc - rx_t0;
            if (rx_off >= CPB + CPB/2 && rx_off <= 8*CPB + CPB/2 && (rx_off % CPB) == CPB/2)
                rx_sh[3'((rx_off - CPB - CPB/2) / CPB)] = tx;
            if (rx_off == 9*CPB + CPB/2) begin
                if (tx !== 1'b1) stop_err++;
                rx_q.push_back(rx_sh);
                rx_start.push_back(rx_t0);
                rx_busy = 1'b0;
            end
        end
        if (done === 1'b1) begin
            done_total++;
            done_cyc = cyc;
        end
    end

    // Feeder: offers feed_buf[0..feed_lim-1], advancing only on accepted cycles
    logic [7:0]  feed_buf [4];
    int unsigned feed_cnt = 0, feed_base = 0, feed_lim = 0;
    logic        acc = 1'b0;

    always @(negedge clk) acc = up_if.i_data_valid && up_if.o_ready;

    initial begin
        int unsigned idx;
        up_if.i_data_valid = 1'b0;
        up_if.i_data       = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (acc) feed_cnt++;
            idx = feed_cnt - feed_base;
            up_if.i_data_valid = (idx < feed_lim);
            up_if.i_data       = (idx < 4) ? feed_buf[idx[1:0]] : 8'h00;
        end
    end

    task automatic wait_done(input int unsigned d0, input string tag);
        int unsigned n = 0;
        while (done_total == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_total - d0 != 0), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] pay [4], input int unsigned exp_count,
                             input logic exp_ovf, input string tag);
        int unsigned base, d0, se0, t_send, n;
        logic [7:0]  exp_b;
        @(negedge clk);
        up_if.i_send = 1'b0;
        repeat (2) @(negedge clk);
        feed_buf  = pay;
        feed_base = feed_cnt;
        feed_lim  = 4;
        base      = rx_q.size();
        d0        = done_total;
        se0       = stop_err;
        up_if.i_send = 1'b1;
        t_send    = cyc;
        @(negedge clk);
        check({tag, "_busy_after_send"}, 32'(busy), 32'd1);

        n = 0;
        while ((feed_cnt - feed_base) < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_ready_when_full"}, 32'(up_if.o_ready), 32'd0);
        check({tag, "_count_when_full"}, 32'(bcnt), 32'd2);
        check({tag, "_ovf_when_full"}, 32'(ovf), 32'd1);

        wait_done(d0, tag);
        repeat (3) @(negedge clk);
        check({tag, "_byte_count"}, 32'(bcnt), exp_count);
        check({tag, "_overflow"}, 32'(ovf), 32'(exp_ovf));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_done_pulses"}, done_total - d0, 32'd1);
        check({tag, "_stop_bits"}, stop_err - se0, 32'd0);
        check({tag, "_chars"}, rx_q.size() - base, 32'd6);
        if (rx_q.size() >= base + 6) begin
            check({tag, "_first_start"}, rx_start[base], t_send + 2);
            for (int k = 0; k < 6; k++) begin
                exp_b = (k == 0) ? HDR0 : (k == 1) ? HDR1 : pay[k-2];
                check($sformatf("%s_char%0d", tag, k), 32'(rx_q[base+k]), 32'(exp_b));
                if (k > 0)
                    check($sformatf("%s_gap%0d", tag, k), rx_start[base+k],
                          rx_start[base+k-1] + CHAR_CYC);
            end
            check({tag, "_done_time"}, done_cyc, rx_start[base+5] + CHAR_CYC);
        end
    endtask

    initial begin
        int unsigned base, d0, nst0, n, s;
        vecs[0].pay = '{8'h11, 8'h22, 8'h33, 8'h44}; vecs[0].exp_count = 4; vecs[0].exp_ovf = 1'b1;
        vecs[1].pay = '{8'h00, 8'hFF, 8'h80, 8'h01}; vecs[1].exp_count = 4; vecs[1].exp_ovf = 1'b1;
        vecs[2].pay = '{8'h55, 8'hAA, 8'h0F, 8'hF0}; vecs[2].exp_count = 4; vecs[2].exp_ovf = 1'b1;

        up_if.i_send = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(up_if.o_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(bcnt), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++)
            run_frame(vecs[i].pay, vecs[i].exp_count, vecs[i].exp_ovf, $sformatf("vec%0d", i));

        // Abort once 0x11 is on the line: 0x22 sitting in the FIFO must be dropped
        up_if.i_send = 1'b0;
        repeat (2) @(negedge clk);
        feed_buf  = '{8'h11, 8'h22, 8'h33, 8'h44};
        feed_base = feed_cnt;
        feed_lim  = 2;
        base      = rx_q.size();
        nst0      = rx_nstart;
        d0        = done_total;
        up_if.i_send = 1'b1;
        n = 0;
        while (rx_nstart < nst0 + 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        up_if.i_send = 1'b0;
        check("abort_count_at_drop", 32'(bcnt), 32'd2);
        wait_done(d0, "abort");
        repeat (3) @(negedge clk);
        check("abort_chars", rx_q.size() - base, 32'd3);
        if (rx_q.size() >= base + 3) begin
            check("abort_char0", 32'(rx_q[base]), 32'(HDR0));
            check("abort_char1", 32'(rx_q[base+1]), 32'(HDR1));
            check("abort_char2", 32'(rx_q[base+2]), 32'h11);
            check("abort_done_time", done_cyc, rx_start[base+2] + CHAR_CYC);
        end
        check("abort_byte_count", 32'(bcnt), 32'd2);
        check("abort_busy_end", 32'(busy), 32'd0);
        check("abort_done_pulses", done_total - d0, 32'd1);

        // Reset in data bit 4 of 0x22 (a low bit), then release with i_send still high
        repeat (2) @(negedge clk);
        feed_buf  = '{8'h11, 8'h22, 8'h33, 8'h44};
        feed_base = feed_cnt;
        feed_lim  = 4;
        nst0      = rx_nstart;
        up_if.i_send = 1'b1;
        n = 0;
        while (rx_nstart < nst0 + 4 && n < 800) begin
            @(negedge clk);
            n++;
        end
        s = rx_t0;
        n = 0;
        while (cyc < s + 5*CPB + CPB/2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_line_low_before", 32'(tx), 32'd0);
        check("midrst_ovf_before", 32'(ovf), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(up_if.o_ready), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_count", 32'(bcnt), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        feed_lim  = 0;
        feed_base = feed_cnt;
        repeat (3) @(negedge clk);
        check("midrst_tx_held", 32'(tx), 32'd1);
        rst = 1'b0;
        nst0 = rx_nstart;
        repeat (60) @(negedge clk);
        check("held_send_busy", 32'(busy), 32'd0);
        check("held_send_no_chars", rx_nstart - nst0, 32'd0);
        check("held_send_tx", 32'(tx), 32'd1);

        run_frame(vecs[0].pay, 4, 1'b1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_uart_sender.md
IMAGE_UART_SENDER -- requirements
Module: image_uart_sender

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter FRAME_BYTES, default 921600, payload bytes per frame (640*480*3).
REQ-003 SHALL have parameter SYNC0/SYNC1, default 8'hA5/8'h5A, header bytes sent before payload.
REQ-004 SHALL use one clock; reset is asynchronous and active-high: i_clk  in  1  system clock; i_rst  in  1  async reset, active-high.
REQ-005 i_send  in  1  frame request from upstream, level; rising edge in IDLE starts a frame.
REQ-006 i_data  in  8  payload byte from upstream SRAM reader.
REQ-007 i_data_valid  in  1  i_data valid this cycle.
REQ-008 o_ready  out  1  block can accept a payload byte this cycle.
REQ-009 o_uart_tx  out  1  serial line, 8N1, idle high.
REQ-010 o_busy  out  1  high in any state except IDLE.
REQ-011 o_done  out  1  one-cycle pulse when last frame bit has left the line.
REQ-012 o_byte_count  out  20  payload bytes accepted in current frame.
REQ-013 o_overflow  out  1  sticky: valid byte offered while o_ready low.

Function
REQ-014 SHALL accept a byte only on a cycle where i_data_valid && o_ready; no other byte is taken.
REQ-015 SHALL buffer accepted bytes in a 2-entry FIFO; o_ready = (state==STREAM) && FIFO not full && o_byte_count < FRAME_BYTES.
REQ-016 SHALL support simultaneous FIFO push and pop in one cycle with occupancy unchanged.
REQ-017 States: IDLE, HEADER, STREAM, DRAIN, DONE.
REQ-018 IDLE->HEADER on i_send rising edge (registered previous i_send); i_send held high from reset does not start a frame.
REQ-019 HEADER: transmit SYNC0 then SYNC1; o_ready low; ->STREAM when SYNC1 loaded into serializer.
REQ-020 STREAM: pop FIFO into serializer whenever serializer idle and FIFO non-empty; ->DRAIN when o_byte_count == FRAME_BYTES.
REQ-021 STREAM with i_send low: abort -> DRAIN immediately, FIFO flushed, byte in flight completes.
REQ-022 DRAIN: continue popping FIFO until empty and serializer idle, then ->DONE.
REQ-023 DONE: assert o_done one cycle, ->IDLE next cycle.
REQ-024 Serializer: on load, start bit (0) begins next cycle; 8 data bits LSB first; stop bit (1); each bit exactly CLKS_PER_BIT cycles; one character = 10*CLKS_PER_BIT cycles.
REQ-025 Back-to-back characters SHALL have no idle gap: next start bit follows stop bit directly when a byte is available.
REQ-026 o_byte_count SHALL clear on IDLE->HEADER, increment on each accept, saturate at FRAME_BYTES.
REQ-027 o_overflow SHALL set when i_data_valid && !o_ready in STREAM, clear only on IDLE->HEADER or reset.
REQ-028 Bit counter width SHALL be $clog2(CLKS_PER_BIT); no wrap before terminal count.

Reset
REQ-029 On i_rst: state IDLE, FIFO empty, o_uart_tx=1, o_ready=0, o_busy=0, o_done=0, o_byte_count=0, o_overflow=0.
REQ-030 Reset mid-character SHALL return o_uart_tx high immediately (asynchronous); partial character discarded.

Structure
REQ-031 State encoding, SYNC defaults and default CLKS_PER_BIT/FRAME_BYTES SHALL live in shared package image_pkg.
REQ-032 Serializer SHALL be sub-module uart_tx_core (i_clk, i_rst, i_load, i_byte, o_tx, o_idle).
REQ-033 FIFO SHALL be inline registers, no vendor RAM.

Verification (CLKS_PER_BIT=4, FRAME_BYTES=4)
REQ-034 Reset then i_send 0->1 -> line shows A5, 5A each 40 cycles, start bit 1 cycle after load.
REQ-035 Feed 11,22,33,44 with valid always high -> line A5,5A,11,22,33,44 gapless; o_done pulse 1 cycle after last stop bit; o_byte_count=4.
REQ-036 Valid asserted 3 cycles while FIFO full -> o_ready low, o_overflow=1, no extra byte transmitted.
REQ-037 Drop i_send after 2 payload bytes -> DRAIN, remaining FIFO flushed, o_done pulses, o_byte_count=2.
REQ-038 Assert i_rst mid-bit 5 of byte 22 -> o_uart_tx=1 same cycle, state IDLE, outputs at reset values.
REQ-039 i_send high through reset release -> no frame starts until i_send toggles low then high.
